// File: rtl/wb_pkg.sv
// Shared constants for the writeback scheduler and its arbiter.
package wb_pkg;
    localparam int XLEN         = 32;
    localparam int REG_AW       = 5;
    localparam int NREG         = 32;
    localparam int NREQ_DEFAULT = 3;

    // Writeback source indices in the request vectors.
    localparam int SRC_ALU = 0;
    localparam int SRC_LSU = 1;
    localparam int SRC_MDU = 2;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the lowest valid index at or after the pointer
// (wrapping), and moves the pointer past the winner when the grant is taken.
module rr_arbiter #(
    parameter int N = 3,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_,
    input  logic [N-1:0]  i_valid,
    input  logic          i_advance,
    output logic [N-1:0]  o_grant,
    output logic [PW-1:0] o_ptr
);
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_gidx;
    logic [N-1:0]  w_grant;
    logic          w_found;

    function automatic int wrap(input int a);
        return (a >= N) ? a - N : a;
    endfunction

    // Search from the pointer upward, wrapping, and take the first valid source.
    always_comb begin
        w_grant = '0;
        w_gidx  = '0;
        w_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!w_found && i_valid[wrap(int'(r_ptr) + k)]) begin
                w_found                          = 1'b1;
                w_grant[wrap(int'(r_ptr) + k)]   = 1'b1;
                w_gidx                           = PW'(wrap(int'(r_ptr) + k));
            end
        end
    end

    // Pointer moves to one past the winner only on a taken grant.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_ptr <= '0;
        end else if (i_advance && w_found) begin
            r_ptr <= (w_gidx == PW'(N - 1)) ? '0 : w_gidx + PW'(1);
        end
    end

    assign o_grant = w_grant;
    assign o_ptr   = r_ptr;
endmodule

// File: rtl/wb_sched.sv
// Writeback scheduler: arbitrates NREQ result sources onto the single register
// file write port through a registered output stage, and keeps the busy
// scoreboard of destination registers reserved at issue.
module wb_sched
    import wb_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_,
    input  logic [NREQ-1:0]        req_valid_i,
    input  logic [REG_AW*NREQ-1:0] req_addr_i,
    input  logic [XLEN*NREQ-1:0]   req_data_i,
    output logic [NREQ-1:0]        req_ready_o,
    output logic                   we_o,
    output logic [REG_AW-1:0]      waddr_o,
    output logic [XLEN-1:0]        wdata_o,
    input  logic                   rsv_i,
    input  logic [REG_AW-1:0]      rsv_addr_i,
    output logic                   rsv_ok_o,
    input  logic [REG_AW-1:0]      raddr1_i,
    input  logic [REG_AW-1:0]      raddr2_i,
    output logic                   hz1_o,
    output logic                   hz2_o,
    output logic [NREG-1:0]        busy_o
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Handshake: a source result is consumed on a clk edge where req_valid_i[i]
    // and req_ready_o[i] are both high; the register file never stalls, so
    // every grant is a consumption.
    logic [NREQ-1:0]   w_grant;
    logic [PW-1:0]     w_ptr;
    logic              w_any;
    logic [REG_AW-1:0] w_gnt_addr;
    logic [XLEN-1:0]   w_gnt_data;
    logic [NREG-1:0]   w_busy_nxt;

    logic              r_we;
    logic [REG_AW-1:0] r_waddr;
    logic [XLEN-1:0]   r_wdata;
    logic [NREG-1:0]   r_busy;

    rr_arbiter #(.N(NREQ)) u_arb (
        .clk       (clk),
        .rst_      (rst_),
        .i_valid   (req_valid_i),
        .i_advance (w_any),
        .o_grant   (w_grant),
        .o_ptr     (w_ptr)
    );

    assign w_any = |w_grant;

    // Select the granted source's address and data.
    always_comb begin
        w_gnt_addr = '0;
        w_gnt_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_gnt_addr = req_addr_i[REG_AW*i +: REG_AW];
                w_gnt_data = req_data_i[XLEN*i +: XLEN];
            end
        end
    end

    // Output register; writes to x0 are consumed but never reach the file.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_we <= w_any && (w_gnt_addr != '0);
            if (w_any && (w_gnt_addr != '0)) begin
                r_waddr <= w_gnt_addr;
                r_wdata <= w_gnt_data;
            end
        end
    end

    assign rsv_ok_o = (rsv_addr_i == '0) | ~r_busy[rsv_addr_i]
                    | (r_we & (r_waddr == rsv_addr_i));

    // Scoreboard update: the write in flight clears, a new reservation sets
    // (and wins over a clear of the same register); x0 is never busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_we) begin
            w_busy_nxt[r_waddr] = 1'b0;
        end
        if (rsv_i && rsv_ok_o && (rsv_addr_i != '0)) begin
            w_busy_nxt[rsv_addr_i] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // A register being written this cycle is forwarded, so it is not a hazard.
    assign hz1_o = r_busy[raddr1_i] & ~(r_we & (r_waddr == raddr1_i));
    assign hz2_o = r_busy[raddr2_i] & ~(r_we & (r_waddr == raddr2_i));

    assign req_ready_o = w_grant;
    assign we_o        = r_we;
    assign waddr_o     = r_waddr;
    assign wdata_o     = r_wdata;
    assign busy_o      = r_busy;

    a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_) $onehot0(w_grant));
    a_grant_valid:  assert property (@(posedge clk) disable iff (!rst_) ((w_grant & ~req_valid_i) == '0));
    a_ptr_range:    assert property (@(posedge clk) disable iff (!rst_) (int'(w_ptr) < NREQ));
endmodule

// File: tb/tb_wb_sched.sv
// Bench for wb_sched: directed scenarios plus random traffic, checked against
// a behavioural model; registered outputs go through an expected queue.
module tb_wb_sched;
    localparam int NREQ = 3;

    logic          clk;
    logic          rst_;
    logic [2:0]    req_valid_i;
    logic [14:0]   req_addr_i;
    logic [95:0]   req_data_i;
    logic [2:0]    req_ready_o;
    logic          we_o;
    logic [4:0]    waddr_o;
    logic [31:0]   wdata_o;
    logic          rsv_i;
    logic [4:0]    rsv_addr_i;
    logic          rsv_ok_o;
    logic [4:0]    raddr1_i;
    logic [4:0]    raddr2_i;
    logic          hz1_o;
    logic          hz2_o;
    logic [31:0]   busy_o;

    wb_sched #(.NREQ(NREQ)) dut (
        .clk         (clk),
        .rst_        (rst_),
        .req_valid_i (req_valid_i),
        .req_addr_i  (req_addr_i),
        .req_data_i  (req_data_i),
        .req_ready_o (req_ready_o),
        .we_o        (we_o),
        .waddr_o     (waddr_o),
        .wdata_o     (wdata_o),
        .rsv_i       (rsv_i),
        .rsv_addr_i  (rsv_addr_i),
        .rsv_ok_o    (rsv_ok_o),
        .raddr1_i    (raddr1_i),
        .raddr2_i    (raddr2_i),
        .hz1_o       (hz1_o),
        .hz2_o       (hz2_o),
        .busy_o      (busy_o)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [69:0] exp_q[$];   // {busy[31:0], we, waddr[4:0], wdata[31:0]}

    // Reference model state (values held after the most recent edge).
    int          m_ptr;
    logic [31:0] m_busy;
    logic        m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // First valid source at or after p, wrapping; -1 when none is valid.
    function automatic int rr_pick(input int p, input logic [2:0] v);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic model_ok(input logic [4:0] a);
        return (a == 5'd0) || !m_busy[a] || (m_we && m_waddr == a);
    endfunction

    function automatic logic model_hz(input logic [4:0] a);
        return m_busy[a] && !(m_we && m_waddr == a);
    endfunction

    task automatic model_reset();
        m_ptr   = 0;
        m_busy  = '0;
        m_we    = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
    endtask

    // Advance the model across one clock edge using the inputs held at it.
    task automatic model_step();
        int          g;
        logic        ok;
        logic [31:0] b;
        logic [4:0]  ga;
        g  = rr_pick(m_ptr, req_valid_i);
        ok = model_ok(rsv_addr_i);
        b  = m_busy;
        if (m_we) b[m_waddr] = 1'b0;
        if (rsv_i && ok && rsv_addr_i != 5'd0) b[rsv_addr_i] = 1'b1;
        m_busy = b;
        m_we   = 1'b0;
        if (g >= 0) begin
            m_ptr = (g + 1) % NREQ;
            ga    = req_addr_i[5*g +: 5];
            if (ga != 5'd0) begin
                m_we    = 1'b1;
                m_waddr = ga;
                m_wdata = req_data_i[32*g +: 32];
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic [2:0] v, input logic [14:0] a, input logic [95:0] d,
                        input logic r, input logic [4:0] ra,
                        input logic [4:0] h1, input logic [4:0] h2);
        int         g;
        logic [2:0] eg;
        @(posedge clk);
        if (rst_) model_step();
        else      model_reset();
        exp_q.push_back({m_busy, m_we, m_waddr, m_wdata});
        #1;
        req_valid_i = v;
        req_addr_i  = a;
        req_data_i  = d;
        rsv_i       = r;
        rsv_addr_i  = ra;
        raddr1_i    = h1;
        raddr2_i    = h2;
        #1;
        g  = rr_pick(m_ptr, v);
        eg = (g >= 0) ? (3'b001 << g) : 3'b000;
        chk("req_ready", 32'(req_ready_o), 32'(eg));
        chk("rsv_ok",    32'(rsv_ok_o),    32'(model_ok(ra)));
        chk("hz1",       32'(hz1_o),       32'(model_hz(h1)));
        chk("hz2",       32'(hz2_o),       32'(model_hz(h2)));
    endtask

    task automatic idle(input logic [4:0] h1);
        step(3'b000, '0, '0, 1'b0, 5'd0, h1, 5'd0);
    endtask

    task automatic reserve(input logic [4:0] ra, input logic [4:0] h1);
        step(3'b000, '0, '0, 1'b1, ra, h1, 5'd0);
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [69:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("we", 32'(we_o), 32'(e[37]));
                chk("busy", busy_o, e[69:38]);
                if (e[37]) begin
                    chk("waddr", 32'(waddr_o), 32'(e[36:32]));
                    chk("wdata", wdata_o, e[31:0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [14:0] ra;
        logic [95:0] rd;
        rst_        = 1'b0;
        req_valid_i = '0;
        req_addr_i  = '0;
        req_data_i  = '0;
        rsv_i       = 1'b0;
        rsv_addr_i  = '0;
        raddr1_i    = '0;
        raddr2_i    = '0;
        model_reset();

        idle(5'd0);
        idle(5'd0);
        #4 rst_ = 1'b1;

        // Round robin with all sources valid.
        repeat (6) step(3'b111, {5'd3, 5'd2, 5'd1},
                        {32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA}, 1'b0, 5'd0, 5'd1, 5'd2);
        idle(5'd0);

        // Single source 2; pointer then wraps to 0.
        step(3'b100, {5'd7, 5'd0, 5'd0}, {32'hDEAD_BEEF, 64'h0}, 1'b0, 5'd0, 5'd7, 5'd0);
        step(3'b111, {5'd3, 5'd2, 5'd1},
             {32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA}, 1'b0, 5'd0, 5'd0, 5'd0);
        idle(5'd0);

        // Reserve x5, write it later; hazard lifts during the write cycle.
        reserve(5'd5, 5'd5);
        idle(5'd5);
        step(3'b001, {10'd0, 5'd5}, {64'h0, 32'h5555_0005}, 1'b0, 5'd0, 5'd5, 5'd5);
        idle(5'd5);
        idle(5'd5);

        // Reservation refused while busy, accepted during the write of x5.
        reserve(5'd5, 5'd5);
        reserve(5'd5, 5'd5);
        step(3'b010, {5'd0, 5'd5, 5'd0}, {32'h0, 32'h0000_0A05, 32'h0}, 1'b0, 5'd0, 5'd5, 5'd0);
        reserve(5'd5, 5'd5);
        idle(5'd5);
        step(3'b010, {5'd0, 5'd5, 5'd0}, {32'h0, 32'h0000_0B05, 32'h0}, 1'b0, 5'd0, 5'd5, 5'd0);
        idle(5'd5);

        // Address 0 result: consumed without a write; x0 never becomes busy.
        step(3'b010, {5'd0, 5'd0, 5'd0}, {32'h0, 32'h0000_1234, 32'h0}, 1'b0, 5'd0, 5'd0, 5'd0);
        step(3'b111, {5'd3, 5'd2, 5'd1},
             {32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA}, 1'b1, 5'd0, 5'd0, 5'd0);
        idle(5'd0);
        idle(5'd0);

        // Asynchronous reset while busy=0xF0 and a write is on the port.
        reserve(5'd4, 5'd0);
        reserve(5'd5, 5'd0);
        reserve(5'd6, 5'd0);
        reserve(5'd7, 5'd0);
        step(3'b001, {10'd0, 5'd9}, {64'h0, 32'h0000_0909}, 1'b0, 5'd0, 5'd0, 5'd0);
        idle(5'd0);
        #4 rst_ = 1'b0;
        #1;
        chk("rst_we", 32'(we_o), 32'h0);
        chk("rst_waddr", 32'(waddr_o), 32'h0);
        chk("rst_wdata", wdata_o, 32'h0);
        chk("rst_busy", busy_o, 32'h0);
        exp_q.delete();
        model_reset();
        idle(5'd0);
        #4 rst_ = 1'b1;

        // Random traffic over a small register window for frequent collisions.
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                ra[5*i +: 5]  = 5'($urandom_range(0, 7));
                rd[32*i +: 32] = $urandom;
            end
            step(3'($urandom_range(0, 7)), ra, rd, 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        idle(5'd0);
        idle(5'd0);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/wb_sched.md
# wb_sched

Writeback scheduler and scoreboard for the 32×32 register file. Owns the register file's single write port and shares it between NREQ writeback sources (ALU, load/store unit, mul/div unit) under round-robin arbitration, with a one-cycle registered output. Tracks destination registers reserved at issue, so decode can stall reads of values still in flight. Sits between the execution units and the register file; its write outputs drive the register file's write-enable, write-address and write-data inputs directly.

## Interface
Parameters:
- NREQ, 3, number of writeback sources (2..8)

Ports:
- clk  in  1  clock
- rst_  in  1  asynchronous active-low reset
- req_valid_i  in  NREQ  source i has a result
- req_addr_i  in  5*NREQ  destination register of source i, slice [5i+4:5i]
- req_data_i  in  32*NREQ  result of source i, slice [32i+31:32i]
- req_ready_o  out  NREQ  one-hot grant; the result is consumed on a clk edge when valid&ready
- we_o  out  1  register file write enable
- waddr_o  out  5  register file write address
- wdata_o  out  32  register file write data
- rsv_i  in  1  issue requests a reservation of rsv_addr_i
- rsv_addr_i  in  5  destination register to reserve
- rsv_ok_o  out  1  reservation may be taken this cycle
- raddr1_i, raddr2_i  in  5 each  decode read addresses
- hz1_o, hz2_o  out  1 each  read hazard: operand not yet available
- busy_o  out  32  scoreboard vector

## Operation
- Arbitration: combinational round-robin over req_valid_i, starting from pointer ptr. The lowest index at or after ptr, modulo NREQ, is granted. At most one req_ready_o bit is high, and only where valid is high.
- The register file never back-pressures, so a grant is always accepted. On a granted edge, ptr becomes (grant index + 1) mod NREQ. With no grant, ptr is held.
- Output stage: on the edge after a grant, we_o=1, waddr_o=granted addr, wdata_o=granted data. With no grant, we_o=0 and waddr_o/wdata_o hold their previous values.
- Address 0: the result is granted and consumed, but we_o stays 0 for it. The pointer still advances.
- Scoreboard busy[31:0]. busy[0] is constant 0.
  - Set: on an edge where rsv_i&rsv_ok_o and rsv_addr_i≠0.
  - Clear: on an edge where we_o=1, for waddr_o.
  - Same register set and cleared on the same edge: set wins.
- rsv_ok_o = (rsv_addr_i==0) | ~busy[rsv_addr_i] | (we_o & waddr_o==rsv_addr_i). rsv_i while rsv_ok_o=0 is ignored; issue must stall.
- Hazards: hzN_o = busy[raddrN_i] & ~(we_o & waddr_o==raddrN_i). The register file forwards the data in flight, so a register being written this cycle is not a hazard.
- A write to a register that is not busy is performed normally; the clear is a no-op.
- busy_o = busy.

## Timing
- Reset (async assert, sync release): we_o=0, waddr_o=0, wdata_o=0, busy=0, ptr=0, so req_ready_o depends only on valid. Results pending in sources are dropped; sources must re-present them after reset.
- Latency: grant edge → we_o high for exactly one cycle after it. The register file is written on the following edge.
- Throughput: one write per cycle, sustained.
- Fairness: with all NREQ sources continuously valid, each source is granted once every NREQ cycles.
- req_ready_o, rsv_ok_o and hz*_o are combinational. No combinational path exists from req_* inputs to we_o/waddr_o/wdata_o.
- Simultaneous events:
  - Reservation of reg r on the same edge as a write to r: r ends busy.
  - Grant to source i on the same edge as the source drops valid: not possible, because the grant requires valid.

## Structure
- Package wb_pkg: XLEN=32, REG_AW=5, NREG=32, NREQ_DEFAULT=3, source indices SRC_ALU=0, SRC_LSU=1, SRC_MDU=2.
- Sub-module rr_arbiter (parameter N): takes valid[N] and the advance strobe; provides the one-hot grant and the internal pointer. It is reused later for the memory port.
- The scoreboard and output register stay in wb_sched.

## Test plan
- Reset mid-stream: with busy=0x0000_00F0 and we_o=1, assert rst_=0 asynchronously → outputs and busy go to 0 immediately, before any clk edge.
- Round robin: all 3 sources valid for 6 cycles with addrs 1/2/3 and data A/B/C → grants 0,1,2,0,1,2. we_o stays high from cycle 1, with waddr sequence 1,2,3,1,2,3.
- Single source: only source 2 valid, addr 7, data 0xDEADBEEF → req_ready_o=3'b100 at once. Next cycle we_o=1, waddr_o=7, wdata_o=0xDEADBEEF, and ptr=0.
- Scoreboard: reserve x5, then x5 written 3 cycles later. hz1_o stays 1 for raddr1_i=5 until the we_o cycle, where it is 0. busy_o[5]=0 after that edge.
- Reserve x5 while busy and not being written → rsv_ok_o=0, busy unchanged. Reserve x5 in the cycle where we_o=1 and waddr_o=5 → rsv_ok_o=1, and busy[5] stays 1.
- Source 1 valid with addr 0, data 0x1234 → granted, ptr advances to 2, we_o stays 0, busy unchanged. Reserving x0 gives rsv_ok_o=1 and busy_o[0] stays 0.
